// File: rtl/addsub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM states,
// step-counter sizing and parameter legality.
package addsub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bits needed to count 0..steps-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned steps);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < steps) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned bpc);
        return (width >= 2) && (bpc >= 1) && (bpc <= width) && ((width % bpc) == 0);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder; chained to build one slice per clock.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE bits per clock through a chain
// of full-adder cells, registered carry between slices, start/busy/done handshake.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW    = cnt_width(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    if (!params_ok(WIDTH, BITS_PER_CYCLE)) begin : g_param_err
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [BITS_PER_CYCLE:0]   chain_c;
    logic [BITS_PER_CYCLE-1:0] slice_s;
    logic [WIDTH-1:0]          res_next;

    assign chain_c[0] = carry_q;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a_sh_q[i]),
            .b    (b_sh_q[i]),
            .cin  (chain_c[i]),
            .sum  (slice_s[i]),
            .cout (chain_c[i+1])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        res_next = res_sh_q >> BITS_PER_CYCLE;
        res_next[WIDTH-1 -: BITS_PER_CYCLE] = slice_s;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_sh_d   = a;
                    b_sh_d   = sub ? ~b : b;
                    carry_d  = sub ? ~cin : cin;
                    cnt_d    = '0;
                    res_sh_d = '0;
                end
            end
            RUN: begin
                // Result bits enter at the top so after STEPS slices they sit in place.
                a_sh_d   = a_sh_q >> BITS_PER_CYCLE;
                b_sh_d   = b_sh_q >> BITS_PER_CYCLE;
                res_sh_d = res_next;
                carry_d  = chain_c[BITS_PER_CYCLE];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sum_d   = res_next;
                    cout_d  = chain_c[BITS_PER_CYCLE];
                    ovf_d   = chain_c[BITS_PER_CYCLE] ^ chain_c[BITS_PER_CYCLE-1];
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and table-driven checks of serial_addsub in three configurations.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // W8 / BPC1
    logic       start8 = 0, sub8 = 0, cin8 = 0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    // W8 / BPC4
    logic       start4 = 0, sub4 = 0, cin4 = 0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;
    // W16 / BPC2
    logic        start16 = 0, sub16 = 0, cin16 = 0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));
    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4));
    serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16));

    int checks = 0;
    int failures = 0;
    logic [7:0] prev_sum8 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];

    // Drives inputs now, waits for the accepting edge and counts edges to done.
    // poke > 0 pulses start (with junk operands) after that many run edges.
    task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input int poke, output int lat);
        sub8 = s; a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        sub8 = ~s; a8 = 8'hAA; b8 = 8'h55; cin8 = ~c;
        chk("busy_after_accept", 32'(busy8), 32'd1);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (start8) start8 = 1'b0;
            if (done8) begin
                lat = n;
                break;
            end
            if (n == 4) chk("sum_held_in_run", 32'(sum8), 32'(prev_sum8));
            if (n == poke) start8 = 1'b1;
        end
    endtask

    initial begin
        int lat;
        logic [15:0] ea, eb;
        logic        es, ec, ecin;
        logic [16:0] full;
        logic        eovf;

        vecs[0] = '{1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 8'h05, 8'h03, 1'b1, 8'h01, 1'b1, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_sum", 32'(sum8), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back in the done cycle of the previous one.
        for (int i = 0; i < 8; i++) begin
            run8(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin, 0, lat);
            chk($sformatf("lat[%0d]", i), 32'(lat), 32'd8);
            chk($sformatf("sum[%0d]", i), 32'(sum8), 32'(vecs[i].exp_sum));
            chk($sformatf("cout[%0d]", i), 32'(cout8), 32'(vecs[i].exp_cout));
            chk($sformatf("ovf[%0d]", i), 32'(ovf8), 32'(vecs[i].exp_ovf));
            prev_sum8 = vecs[i].exp_sum;
        end
        @(posedge clk); #1;
        chk("done_single_pulse", 32'(done8), 32'd0);
        chk("idle_after_done", 32'(busy8), 32'd0);

        // start during run is ignored
        run8(1'b0, 8'h12, 8'h34, 1'b0, 3, lat);
        chk("ign_lat", 32'(lat), 32'd8);
        chk("ign_sum", 32'(sum8), 32'h46);
        prev_sum8 = 8'h46;
        begin
            int extra;
            extra = 0;
            for (int n = 0; n < 12; n++) begin
                @(posedge clk); #1;
                if (done8 || busy8) extra++;
            end
            chk("ign_no_extra_op", 32'(extra), 32'd0);
        end

        // async reset mid-run, with nonzero prior results
        run8(1'b1, 8'h05, 8'h03, 1'b1, 0, lat);
        chk("pre_rst_cout", 32'(cout8), 32'd1);
        sub8 = 1'b0; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum", 32'(sum8), 32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        prev_sum8 = '0;
        begin
            int seen;
            seen = 0;
            for (int n = 0; n < 12; n++) begin
                @(posedge clk); #1;
                if (done8 || busy8) seen++;
            end
            chk("no_done_after_rst", 32'(seen), 32'd0);
        end

        // W8 / BPC4: 0x80 - 0x01
        @(negedge clk);
        sub4 = 1'b1; a4 = 8'h80; b4 = 8'h01; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (done4) begin lat = n; break; end
        end
        chk("bpc4_lat", 32'(lat), 32'd2);
        chk("bpc4_sum", 32'(sum4), 32'h7F);
        chk("bpc4_cout", 32'(cout4), 32'd1);
        chk("bpc4_ovf", 32'(ovf4), 32'd1);

        // W16 / BPC2: random back-to-back against a reference model
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            ea = 16'($urandom); eb = 16'($urandom);
            es = 1'($urandom); ec = 1'($urandom);
            if (i == 0) begin ea = 16'h7FFF; eb = 16'h0001; es = 1'b0; ec = 1'b0; end
            if (i == 1) begin ea = 16'h8000; eb = 16'h0001; es = 1'b1; ec = 1'b0; end
            sub16 = es; a16 = ea; b16 = eb; cin16 = ec; start16 = 1'b1;
            @(posedge clk); #1;
            start16 = 1'b0;
            a16 = ~ea; b16 = ~eb;
            lat = -1;
            for (int n = 1; n <= 20; n++) begin
                @(posedge clk); #1;
                if (done16) begin lat = n; break; end
            end
            if (es) begin
                eb = ~eb;
                ecin = ~ec;
            end else begin
                ecin = ec;
            end
            full = {1'b0, ea} + {1'b0, eb} + {16'd0, ecin};
            eovf = (ea[15] == eb[15]) && (full[15] != ea[15]);
            chk($sformatf("w16_lat[%0d]", i), 32'(lat), 32'd8);
            chk($sformatf("w16_sum[%0d]", i), 32'(sum16), 32'(full[15:0]));
            chk($sformatf("w16_cout[%0d]", i), 32'(cout16), 32'(full[16]));
            chk($sformatf("w16_ovf[%0d]", i), 32'(ovf16), 32'(eovf));
            if (lat < 0) break;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
